// File: rtl/tff_counter.sv
// rtl/tff_counter.sv - parametrised toggle/up/down counter register with load, clamp and wrap/saturate
module tff_counter #(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 2 ** WIDTH,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam int EW = WIDTH + 1;
    localparam logic [EW-1:0]    MAX_EXT = EW'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_TOGGLE = 2'b01,
        MODE_UP     = 2'b10,
        MODE_DOWN   = 2'b11
    } mode_t;

    mode_t            cur_mode;
    logic [EW-1:0]    q_ext;
    logic [EW-1:0]    toggle_ext;
    logic [EW-1:0]    load_ext;
    logic [EW-1:0]    up_ext;
    logic [EW-1:0]    down_ext;
    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] q_next;
    logic             wrap_next;

    assign cur_mode = mode_t'(mode);

    // Extra top bit keeps toggle/load results above the range visible for clamping.
    always_comb begin
        q_ext      = {1'b0, q};
        toggle_ext = {1'b0, q ^ t};
        load_ext   = {1'b0, load_value};
        up_ext     = q_ext + EW'(1);
        down_ext   = q_ext - EW'(1);
        at_max     = (q_ext == MAX_EXT);
        at_zero    = (q_ext == '0);
    end

    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        if (load) begin
            q_next = (load_ext > MAX_EXT) ? MAX_Q : load_value;
        end else if (en) begin
            case (cur_mode)
                MODE_TOGGLE: begin
                    q_next = (toggle_ext > MAX_EXT) ? MAX_Q : WIDTH'(toggle_ext);
                end
                MODE_UP: begin
                    if (!at_max) begin
                        q_next = WIDTH'(up_ext);
                    end else if (!SATURATE) begin
                        q_next    = '0;
                        wrap_next = 1'b1;
                    end
                end
                MODE_DOWN: begin
                    if (!at_zero) begin
                        q_next = WIDTH'(down_ext);
                    end else if (!SATURATE) begin
                        q_next    = MAX_Q;
                        wrap_next = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Terminal count predicts a wrap or saturation at the coming edge.
    assign tc = en && !load &&
                ((cur_mode == MODE_UP && at_max) || (cur_mode == MODE_DOWN && at_zero));

    always_ff @(posedge clock) begin
        if (reset) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            q    <= q_next;
            wrap <= wrap_next;
        end
    end

endmodule

// File: tb/tb_tff_counter.sv
// tb/tb_tff_counter.sv - scoreboard bench for tff_counter, decade wrap and saturate instances
module tb_tff_counter;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] t = 4'd0;
    logic       load = 1'b0;
    logic [3:0] load_value = 4'd0;
    logic [3:0] q_w, q_s;
    logic       tc_w, tc_s;
    logic       wrap_w, wrap_s;

    always #5 clock = ~clock;

    tff_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut_wrap (
        .clock(clock), .reset(reset), .en(en), .mode(mode), .t(t),
        .load(load), .load_value(load_value), .q(q_w), .tc(tc_w), .wrap(wrap_w)
    );

    tff_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) dut_sat (
        .clock(clock), .reset(reset), .en(en), .mode(mode), .t(t),
        .load(load), .load_value(load_value), .q(q_s), .tc(tc_s), .wrap(wrap_s)
    );

    typedef struct {
        int         idx;
        logic       tc0;
        logic [3:0] q0;
        logic       w0;
        logic       tc1;
        logic [3:0] q1;
        logic       w1;
    } exp_t;

    exp_t sb[$];
    int   assertions = 0;
    int   failures = 0;
    int   pushed = 0;
    int   popped = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic ld, input logic [3:0] lv, input logic e,
                        input logic [1:0] m, input logic [3:0] tt,
                        input logic etc0, input logic [3:0] eq0, input logic ew0,
                        input logic etc1, input logic [3:0] eq1, input logic ew1);
        exp_t x;
        @(negedge clock);
        reset      = r;
        load       = ld;
        load_value = lv;
        en         = e;
        mode       = m;
        t          = tt;
        x.idx = pushed;
        x.tc0 = etc0; x.q0 = eq0; x.w0 = ew0;
        x.tc1 = etc1; x.q1 = eq1; x.w1 = ew1;
        sb.push_back(x);
        pushed++;
    endtask

    // Monitor: tc sampled mid-cycle with the new inputs, q/wrap just after the edge.
    initial begin
        logic tc0_s, tc1_s;
        exp_t x;
        forever begin
            wait (sb.size() > 0);
            #2;
            tc0_s = tc_w;
            tc1_s = tc_s;
            @(posedge clock);
            #1;
            x = sb[0];
            chk("tc_wrapinst", x.idx, 32'(tc0_s), 32'(x.tc0));
            chk("q_wrapinst", x.idx, 32'(q_w), 32'(x.q0));
            chk("wrap_wrapinst", x.idx, 32'(wrap_w), 32'(x.w0));
            chk("tc_satinst", x.idx, 32'(tc1_s), 32'(x.tc1));
            chk("q_satinst", x.idx, 32'(q_s), 32'(x.q1));
            chk("wrap_satinst", x.idx, 32'(wrap_s), 32'(x.w1));
            void'(sb.pop_front());
            popped++;
        end
    end

    initial begin
        logic [3:0] dq0 [5] = '{4'd1, 4'd0, 4'd9, 4'd8, 4'd7};
        logic       dw0 [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic       dt0 [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [3:0] dq1 [5] = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
        logic       dt1 [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        // Reset beats a concurrent load, then release.
        step(1, 1, 4'd5, 0, 2'b00, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0);
        step(1, 1, 4'd5, 0, 2'b00, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0);
        step(0, 0, 4'd0, 0, 2'b00, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0);

        // Decade count up from 0; wrap instance wraps, saturate instance sticks at 9.
        for (int k = 1; k <= 10; k++) begin
            step(0, 0, 4'd0, 1, 2'b10, 4'd0,
                 (k == 10), 4'(k % 10), (k == 10),
                 (k == 10), (k == 10) ? 4'd9 : 4'(k), 1'b0);
        end

        // Load 2 with en and mode active: load wins, tc suppressed.
        step(0, 1, 4'd2, 1, 2'b11, 4'd0, 0, 4'd2, 0, 0, 4'd2, 0);
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 4'd0, 1, 2'b11, 4'd0, dt0[k], dq0[k], dw0[k], dt1[k], dq1[k], 1'b0);
        end

        // Toggle mode from 0, including a clamp of 14 down to 9.
        step(1, 0, 4'd0, 0, 2'b00, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0);
        step(0, 0, 4'd0, 1, 2'b01, 4'b0101, 0, 4'd5, 0, 0, 4'd5, 0);
        step(0, 0, 4'd0, 1, 2'b01, 4'b0011, 0, 4'd6, 0, 0, 4'd6, 0);
        step(0, 0, 4'd0, 1, 2'b01, 4'b1000, 0, 4'd9, 0, 0, 4'd9, 0);
        step(0, 0, 4'd0, 1, 2'b01, 4'b0000, 0, 4'd9, 0, 0, 4'd9, 0);

        // Load of 15 clamps to 9 over a count-up at terminal count; then hold with en=0.
        step(0, 1, 4'd15, 1, 2'b10, 4'd0, 0, 4'd9, 0, 0, 4'd9, 0);
        step(0, 0, 4'd0, 0, 2'b10, 4'd0, 0, 4'd9, 0, 0, 4'd9, 0);

        // Reset mid-count at q=7, then counting resumes from 0.
        step(0, 1, 4'd6, 0, 2'b00, 4'd0, 0, 4'd6, 0, 0, 4'd6, 0);
        step(0, 0, 4'd0, 1, 2'b10, 4'd0, 0, 4'd7, 0, 0, 4'd7, 0);
        step(1, 0, 4'd0, 1, 2'b10, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0);
        step(0, 0, 4'd0, 1, 2'b10, 4'd0, 0, 4'd1, 0, 0, 4'd1, 0);
        step(0, 0, 4'd0, 1, 2'b10, 4'd0, 0, 4'd2, 0, 0, 4'd2, 0);

        for (int i = 0; i < 20 && popped < pushed; i++) @(posedge clock);
        #3;
        if (popped != pushed) begin
            assertions++;
            failures++;
            $display("FAIL drain: checked %0d expected %0d", popped, pushed);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: time %0t limit 50000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/tff_counter.md
# tff_counter

Parametrised synchronous toggle/counter register: the multi-bit, multi-mode successor to the single-bit T flip-flop. It holds a WIDTH-bit state that can hold, toggle under a per-bit mask, count up, or count down modulo MODULUS, with wrap or saturate behaviour selectable at elaboration. It also supports a parallel load and flags terminal count. It is used as the generic counter/toggle primitive in lab datapaths, for example as a decade counter or clock-divider stage.

## Interface
- WIDTH, 8, state width in bits (>= 1).
- MODULUS, 2**WIDTH, count range is 0 .. MODULUS-1 (2 <= MODULUS <= 2**WIDTH).
- SATURATE, 0, 0 = wrap at range ends; 1 = stick at range ends.

- clock  input  1  rising-edge clock.
- reset  input  1  reset, synchronous, active-high; clock clock.
- en  input  1  enables mode operation; load ignores en.
- mode  input  2  00 hold, 01 toggle-mask, 10 count up, 11 count down.
- t  input  WIDTH  per-bit toggle mask (mode 01 only).
- load  input  1  parallel load strobe.
- load_value  input  WIDTH  value for load.
- q  output  WIDTH  registered state.
- tc  output  1  combinational terminal-count flag.
- wrap  output  1  registered one-cycle pulse after a wrap.

## Operation
- Invariant: q <= MODULUS-1 at all times after reset.
- Priority at each rising edge: reset > load > (en && mode) > hold.
- reset: q <= 0, wrap <= 0.
- load: q <= min(load_value, MODULUS-1); wrap <= 0.
- en=0 or mode=00: q holds; wrap <= 0.
- mode 01, toggle:
  - r = q ^ t, with each bit behaving as a T flip-flop (t[i]=1 inverts bit i, t[i]=0 holds).
  - q <= r if r <= MODULUS-1, else q <= MODULUS-1.
  - wrap <= 0.
- mode 10, count up:
  - If q < MODULUS-1: q <= q+1.
  - If q == MODULUS-1 and SATURATE=0: q <= 0, wrap <= 1.
  - If q == MODULUS-1 and SATURATE=1: q holds, wrap <= 0.
- mode 11, count down:
  - If q > 0: q <= q-1.
  - If q == 0 and SATURATE=0: q <= MODULUS-1, wrap <= 1.
  - If q == 0 and SATURATE=1: q holds, wrap <= 0.
- tc = en && !load && ((mode==10 && q==MODULUS-1) || (mode==11 && q==0)).
  - tc is asserted whether or not SATURATE is set.
  - tc is never asserted in modes 00 or 01.
- Arithmetic is done in WIDTH+1 bits internally. No carry out of WIDTH bits is ever visible on q.

## Timing
- q latency: one clock. A change on any input is reflected in q after the next rising edge.
- tc is purely combinational from q, en, load and mode, so it is valid in the same cycle. It predicts a wrap or saturation at the next edge.
- wrap is high for exactly the one cycle following the edge that wrapped. In continuous up-counting with MODULUS=M, wrap pulses once every M cycles.
- load concurrent with en and any mode: load wins, and wrap <= 0.
- Reset mid-count: q=0 and wrap=0 from the first edge at which reset is sampled high. reset overrides a concurrent load.
- Mode change takes effect at the edge at which the new mode is sampled. No pipeline state is carried between modes.
- Power-up, before the first reset: q is undefined. Benches must assert reset for at least one edge.

## Test plan
- Reset: hold reset=1 for 2 edges with load=1, load_value=5 -> q=0 and wrap=0; release reset -> q still 0.
- Decade wrap (WIDTH=4, MODULUS=10, SATURATE=0), en=1, mode=10 from q=0:
  - q steps 1..9, then 0.
  - tc=1 while q=9.
  - wrap=1 exactly in the cycle when q=0 after the wrap.
- Down-count and saturate (WIDTH=4, MODULUS=10, SATURATE=1), load 2, then mode=11 for 5 edges:
  - q goes 1, 0, 0, 0, 0.
  - tc=1 while q=0.
  - wrap never asserts.
- Toggle mode (WIDTH=4, MODULUS=10), from q=0, mode=01:
  - t=0101 -> q=5.
  - t=0011 -> q=6.
  - t=1000 -> r=14 is clamped, so q=9.
  - t=0000 -> q holds at 9.
- Priority and clamp (WIDTH=4, MODULUS=10):
  - load=1, load_value=15, en=1, mode=10 -> q=9, wrap=0, and tc=0 in that cycle.
  - en=0 next cycle -> q holds at 9.
- Reset mid-count: counting up at q=7, assert reset for one edge -> q=0; counting resumes at 1 on the following edge.
